hub75_column_driver: RTL and testbench
======================================

Name: hub75_column_driver

Overview:
- Panel-side consumer of the column stream that the frame manager produces.
- Each scan line: pulses hub75_ready, captures one pair of columns plus scan address on data_valid, then drives the HUB75 panel.
- Panel drive uses bit-plane (binary-code) modulation: shift, latch, display per plane, over RGB_RES/3 planes.
- After the last plane it requests the next column pair.

Parameters:
- NUM_ROWS, 64, pixels per column; pixels shifted per plane.
- SCAN_RATE, 32, number of scan addresses; address width is $clog2(SCAN_RATE).
- RGB_RES, 9, bits per pixel. Layout is R=[8:6], G=[5:3], B=[2:0]. Bit planes BP = RGB_RES/3.
- BASE_TIME, 8, display cycles for plane 0; plane p displays BASE_TIME<<p cycles.
- READY_TIMEOUT, 1024, cycles to wait for data_valid before re-pulsing hub75_ready.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- columns  input  [1:0][NUM_ROWS-1:0][RGB_RES-1:0]  [0] is the upper half-panel, [1] the lower
- col_num1  input  $clog2(SCAN_RATE)  scan address for this pair
- data_valid  input  1  one-cycle strobe; columns and col_num1 valid in the same cycle
- hub75_ready  output  1  one-cycle request for the next pair
- hub75_addr  output  $clog2(SCAN_RATE)  panel row address A..E
- hub75_r0, hub75_g0, hub75_b0  output  1 each  upper-half pixel data
- hub75_r1, hub75_g1, hub75_b1  output  1 each  lower-half pixel data
- hub75_clk  output  1  panel shift clock
- hub75_lat  output  1  panel latch
- hub75_oe  output  1  output enable, active low
- busy  output  1  high in every state except REQ and WAIT

Behaviour:
- Reset values (in the cycle after rst_in is sampled high):
  - hub75_ready=0, hub75_addr=0, all rgb=0, hub75_clk=0, hub75_lat=0, hub75_oe=1, busy=0.
  - Internal: plane=0, pixel=0, timer=0, state=REQ.
- Reset mid-operation aborts immediately to these values; no partial latch is emitted.
- All outputs are registered.
- States: REQ -> WAIT -> SHIFT -> LATCH -> DISPLAY -> (SHIFT or REQ).
- REQ (1 cycle): hub75_ready=1; timer cleared. Next state is WAIT.
- WAIT:
  - hub75_ready=0; timer counts up each cycle.
  - On data_valid=1: capture columns and col_num1 into internal registers; plane=0, pixel=0; go to SHIFT.
  - If timer reaches READY_TIMEOUT-1 with no data_valid: go to REQ. This covers a lost handshake.
  - data_valid in the same cycle as the timeout wins (capture, no re-request).
  - data_valid in any state other than WAIT is ignored; the captured registers are not modified.
- SHIFT:
  - 2 cycles per pixel, hub75_oe=1 throughout.
  - Phase A: drive rgb0 from captured[0][pixel] and rgb1 from captured[1][pixel], bit `plane` of each colour field; hub75_clk=0.
  - Phase B: hold data; hub75_clk=1.
  - Pixel 0 is shifted first. After phase B of pixel NUM_ROWS-1, go to LATCH.
  - Total 2*NUM_ROWS cycles.
- LATCH (1 cycle): hub75_lat=1, hub75_clk=0, hub75_oe=1; hub75_addr <= captured col_num1.
- DISPLAY:
  - hub75_oe=0 for exactly BASE_TIME<<plane cycles; hub75_lat=0.
  - Then hub75_oe=1. If plane==BP-1, go to REQ; else plane+1 and go to SHIFT with pixel=0.
- Cycle budget per pair = 1 (REQ) + wait + BP*(2*NUM_ROWS+1) + BASE_TIME*(2^BP-1).
  - With defaults: 1 + wait + 387 + 56.
- hub75_oe and hub75_lat are never simultaneously active: oe=0 never coincides with lat=1.
- Plane timer width must hold BASE_TIME<<(BP-1); READY_TIMEOUT counter must hold READY_TIMEOUT-1 without wrap.
- hub75_addr changes only in LATCH. col_num1 = SCAN_RATE-1 is legal and must not wrap.

Test Plan:
- Reset, then release -> first cycle has hub75_ready=1 for exactly 1 cycle, oe=1, lat=0, addr=0; busy=0 until data_valid.
- data_valid 2 cycles after ready, col_num1=5, all pixels 9'h1FF -> 3 × 64 clk rising edges with rgb=1, 3 lat pulses, addr=5 from the first LATCH, oe low runs of 8/16/32 cycles, then ready pulses again.
- Upper pixel i=9'b100_010_001, lower=0 -> plane0: r0=0,g0=0,b0=1; plane1: g0=1 only; plane2: r0=1 only; r1/g1/b1=0 throughout.
- No data_valid after ready -> ready re-pulses exactly READY_TIMEOUT+1 cycles after the previous pulse; outputs are otherwise idle.
- data_valid pulsed during SHIFT with different columns -> shifted data and addr unchanged from the original capture.
- rst_in asserted mid-DISPLAY of plane 1 -> next cycle oe=1, lat=0, addr=0, then REQ ready pulse after release.

Source files
------------

// File: rtl/hub75_column_driver.sv
// HUB75 column driver: captures one upper/lower column pair per scan line and
// drives it to the panel using binary-code modulation over RGB_RES/3 bit planes.
module hub75_column_driver #(
   parameter int unsigned NUM_ROWS      = 64,
   parameter int unsigned SCAN_RATE     = 32,
   parameter int unsigned RGB_RES       = 9,
   parameter int unsigned BASE_TIME     = 8,
   parameter int unsigned READY_TIMEOUT = 1024
) (
   input  logic                                  clk_in,
   input  logic                                  rst_in,
   input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] columns,
   input  logic [$clog2(SCAN_RATE)-1:0]          col_num1,
   input  logic                                  data_valid,
   output logic                                  hub75_ready,
   output logic [$clog2(SCAN_RATE)-1:0]          hub75_addr,
   output logic                                  hub75_r0,
   output logic                                  hub75_g0,
   output logic                                  hub75_b0,
   output logic                                  hub75_r1,
   output logic                                  hub75_g1,
   output logic                                  hub75_b1,
   output logic                                  hub75_clk,
   output logic                                  hub75_lat,
   output logic                                  hub75_oe,
   output logic                                  busy
);

   localparam int unsigned ADDR_W   = $clog2(SCAN_RATE);
   localparam int unsigned BP       = RGB_RES / 3;
   localparam int unsigned PIX_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int unsigned PLANE_W  = (BP > 1) ? $clog2(BP) : 1;
   localparam int unsigned DISP_MAX = BASE_TIME << (BP - 1);
   localparam int unsigned TMO_MAX  = READY_TIMEOUT - 1;
   localparam int unsigned TMR_MAX  = (DISP_MAX > TMO_MAX) ? DISP_MAX : TMO_MAX;
   localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);

   typedef enum logic [2:0] {
      S_REQ     = 3'd0,
      S_WAIT    = 3'd1,
      S_SHIFT   = 3'd2,
      S_LATCH   = 3'd3,
      S_DISPLAY = 3'd4
   } state_t;

   state_t                                r_state, w_state_nxt;
   logic [PLANE_W-1:0]                    r_plane, w_plane_nxt;
   logic [PIX_W-1:0]                      r_pixel, w_pixel_nxt;
   logic                                  r_phase, w_phase_nxt;
   logic [TMR_W-1:0]                      r_timer, w_timer_nxt;
   logic                                  w_capture;

   logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] r_cols;
   logic [ADDR_W-1:0]                     r_col_num;

   logic                                  r_ready, w_ready;
   logic [ADDR_W-1:0]                     r_addr, w_addr;
   logic [2:0]                            r_rgb0, w_rgb0;
   logic [2:0]                            r_rgb1, w_rgb1;
   logic                                  r_hclk, w_hclk;
   logic                                  r_lat, w_lat;
   logic                                  r_oe, w_oe;
   logic                                  r_busy, w_busy;

   logic [TMR_W-1:0]                      w_disp_len;
   logic                                  w_disp_last;
   logic [BP-1:0]                         w_up_r, w_up_g, w_up_b;
   logic [BP-1:0]                         w_lo_r, w_lo_g, w_lo_b;

   // Plane p is displayed for BASE_TIME<<p cycles.
   assign w_disp_len  = TMR_W'(BASE_TIME) << r_plane;
   assign w_disp_last = (r_timer == (w_disp_len - TMR_W'(1)));

   assign w_up_r = r_cols[0][r_pixel][2*BP +: BP];
   assign w_up_g = r_cols[0][r_pixel][BP   +: BP];
   assign w_up_b = r_cols[0][r_pixel][0    +: BP];
   assign w_lo_r = r_cols[1][r_pixel][2*BP +: BP];
   assign w_lo_g = r_cols[1][r_pixel][BP   +: BP];
   assign w_lo_b = r_cols[1][r_pixel][0    +: BP];

   // State and sequencing counters.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= S_REQ;
         r_plane <= '0;
         r_pixel <= '0;
         r_phase <= 1'b0;
         r_timer <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_plane <= w_plane_nxt;
         r_pixel <= w_pixel_nxt;
         r_phase <= w_phase_nxt;
         r_timer <= w_timer_nxt;
      end
   end

   // Capture registers only load from WAIT, so strobes elsewhere are ignored.
   always_ff @(posedge clk_in) begin
      if (w_capture) begin
         r_cols    <= columns;
         r_col_num <= col_num1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_plane_nxt = r_plane;
      w_pixel_nxt = r_pixel;
      w_phase_nxt = r_phase;
      w_timer_nxt = r_timer;
      w_capture   = 1'b0;
      case (r_state)
         S_REQ: begin
            w_timer_nxt = '0;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (data_valid) begin
               w_capture   = 1'b1;
               w_plane_nxt = '0;
               w_pixel_nxt = '0;
               w_phase_nxt = 1'b0;
               w_timer_nxt = '0;
               w_state_nxt = S_SHIFT;
            end else if (r_timer == TMR_W'(TMO_MAX)) begin
               w_state_nxt = S_REQ;
            end else begin
               w_timer_nxt = r_timer + TMR_W'(1);
            end
         end
         S_SHIFT: begin
            if (!r_phase) begin
               w_phase_nxt = 1'b1;
            end else begin
               w_phase_nxt = 1'b0;
               if (r_pixel == PIX_W'(NUM_ROWS - 1)) begin
                  w_state_nxt = S_LATCH;
               end else begin
                  w_pixel_nxt = r_pixel + PIX_W'(1);
               end
            end
         end
         S_LATCH: begin
            w_timer_nxt = '0;
            w_state_nxt = S_DISPLAY;
         end
         S_DISPLAY: begin
            if (w_disp_last) begin
               w_timer_nxt = '0;
               if (r_plane == PLANE_W'(BP - 1)) begin
                  w_state_nxt = S_REQ;
               end else begin
                  w_plane_nxt = r_plane + PLANE_W'(1);
                  w_pixel_nxt = '0;
                  w_phase_nxt = 1'b0;
                  w_state_nxt = S_SHIFT;
               end
            end else begin
               w_timer_nxt = r_timer + TMR_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_REQ;
         end
      endcase
   end

   // Panel outputs decoded from the current state, registered one cycle later.
   always_comb begin
      w_ready = 1'b0;
      w_addr  = r_addr;
      w_rgb0  = r_rgb0;
      w_rgb1  = r_rgb1;
      w_hclk  = 1'b0;
      w_lat   = 1'b0;
      w_oe    = 1'b1;
      w_busy  = 1'b1;
      case (r_state)
         S_REQ: begin
            w_ready = 1'b1;
            w_busy  = 1'b0;
         end
         S_WAIT: begin
            w_busy = 1'b0;
         end
         S_SHIFT: begin
            w_rgb0 = {w_up_r[r_plane], w_up_g[r_plane], w_up_b[r_plane]};
            w_rgb1 = {w_lo_r[r_plane], w_lo_g[r_plane], w_lo_b[r_plane]};
            w_hclk = r_phase;
         end
         S_LATCH: begin
            w_lat  = 1'b1;
            w_addr = r_col_num;
         end
         S_DISPLAY: begin
            w_oe = 1'b0;
         end
         default: begin
            w_busy = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_ready <= 1'b0;
         r_addr  <= '0;
         r_rgb0  <= '0;
         r_rgb1  <= '0;
         r_hclk  <= 1'b0;
         r_lat   <= 1'b0;
         r_oe    <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_ready <= w_ready;
         r_addr  <= w_addr;
         r_rgb0  <= w_rgb0;
         r_rgb1  <= w_rgb1;
         r_hclk  <= w_hclk;
         r_lat   <= w_lat;
         r_oe    <= w_oe;
         r_busy  <= w_busy;
      end
   end

   assign hub75_ready = r_ready;
   assign hub75_addr  = r_addr;
   assign hub75_r0    = r_rgb0[2];
   assign hub75_g0    = r_rgb0[1];
   assign hub75_b0    = r_rgb0[0];
   assign hub75_r1    = r_rgb1[2];
   assign hub75_g1    = r_rgb1[1];
   assign hub75_b1    = r_rgb1[0];
   assign hub75_clk   = r_hclk;
   assign hub75_lat   = r_lat;
   assign hub75_oe    = r_oe;
   assign busy        = r_busy;

endmodule

// File: tb/tb_hub75_column_driver.sv
// Directed bench for hub75_column_driver: observes full scan-line sequences
// and compares shifted data, latch, output-enable timing and handshake.
module tb_hub75_column_driver;

   localparam int NR  = 64;
   localparam int SR  = 32;
   localparam int RES = 9;
   localparam int BT  = 8;
   localparam int RT  = 1024;
   localparam int BP  = RES / 3;
   localparam int AW  = $clog2(SR);
   localparam int PAIR_CYC = 1 + BP * (2 * NR + 1) + BT * ((1 << BP) - 1);

   typedef logic [1:0][NR-1:0][RES-1:0] cols_t;

   logic          clk_in = 1'b0;
   logic          rst_in;
   cols_t         columns;
   logic [AW-1:0] col_num1;
   logic          data_valid;
   logic          hub75_ready;
   logic [AW-1:0] hub75_addr;
   logic          hub75_r0, hub75_g0, hub75_b0;
   logic          hub75_r1, hub75_g1, hub75_b1;
   logic          hub75_clk, hub75_lat, hub75_oe, busy;

   hub75_column_driver #(
      .NUM_ROWS(NR), .SCAN_RATE(SR), .RGB_RES(RES),
      .BASE_TIME(BT), .READY_TIMEOUT(RT)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .columns(columns), .col_num1(col_num1),
      .data_valid(data_valid), .hub75_ready(hub75_ready), .hub75_addr(hub75_addr),
      .hub75_r0(hub75_r0), .hub75_g0(hub75_g0), .hub75_b0(hub75_b0),
      .hub75_r1(hub75_r1), .hub75_g1(hub75_g1), .hub75_b1(hub75_b1),
      .hub75_clk(hub75_clk), .hub75_lat(hub75_lat), .hub75_oe(hub75_oe), .busy(busy)
   );

   always #5 clk_in = ~clk_in;

   int n_vec = 0;
   int n_err = 0;

   // Per-pair observations: rec[half][color][plane][pixel].
   logic [NR-1:0] rec [2][3][BP];
   int            n_edge [BP];
   logic [AW-1:0] lat_addr [BP];
   int            runs [8];
   int            n_lat, n_runs, n_overlap, n_addr_bad, n_busy_bad, n_oe_clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   function automatic cols_t pat_const(input logic [RES-1:0] up, input logic [RES-1:0] lo);
      cols_t c;
      for (int i = 0; i < NR; i++) begin
         c[0][i] = up;
         c[1][i] = lo;
      end
      return c;
   endfunction

   // Pixel i carries i[2:0] in every colour field, so plane p shows bit i[p].
   function automatic cols_t pat_idx();
      cols_t      c;
      logic [2:0] k;
      for (int i = 0; i < NR; i++) begin
         k = 3'(i);
         c[0][i] = {k, k, k};
         c[1][i] = ~{k, k, k};
      end
      return c;
   endfunction

   // color 0=R [8:6], 1=G [5:3], 2=B [2:0]
   function automatic logic [NR-1:0] exp_bits(input cols_t c, input int half, input int color,
                                              input int plane);
      logic [NR-1:0]  r;
      logic [RES-1:0] px;
      for (int i = 0; i < NR; i++) begin
         px   = c[half][i];
         r[i] = px[(2 - color) * BP + plane];
      end
      return r;
   endfunction

   // Watches one scan line until the next ready pulse, optionally injecting a stray strobe.
   task automatic run_pair(input int inject_at, input cols_t alt, input logic [AW-1:0] alt_addr,
                           output int cycles);
      logic          prev_clk;
      logic [AW-1:0] prev_addr;
      int            run_len;
      int            n;
      for (int h = 0; h < 2; h++)
         for (int c = 0; c < 3; c++)
            for (int p = 0; p < BP; p++) rec[h][c][p] = '0;
      for (int p = 0; p < BP; p++) begin
         n_edge[p]   = 0;
         lat_addr[p] = '0;
      end
      for (int r = 0; r < 8; r++) runs[r] = 0;
      n_lat = 0; n_runs = 0; n_overlap = 0; n_addr_bad = 0; n_busy_bad = 0; n_oe_clk = 0;
      run_len   = 0;
      prev_clk  = hub75_clk;
      prev_addr = hub75_addr;
      for (n = 1; n <= 5000; n++) begin
         step();
         if (n == inject_at) begin
            columns    = alt;
            col_num1   = alt_addr;
            data_valid = 1'b1;
         end else if (n == inject_at + 1) begin
            data_valid = 1'b0;
         end
         if (hub75_clk && !prev_clk) begin
            if (hub75_oe !== 1'b1) n_oe_clk++;
            if (n_lat < BP) begin
               if (n_edge[n_lat] < NR) begin
                  rec[0][0][n_lat][n_edge[n_lat]] = hub75_r0;
                  rec[0][1][n_lat][n_edge[n_lat]] = hub75_g0;
                  rec[0][2][n_lat][n_edge[n_lat]] = hub75_b0;
                  rec[1][0][n_lat][n_edge[n_lat]] = hub75_r1;
                  rec[1][1][n_lat][n_edge[n_lat]] = hub75_g1;
                  rec[1][2][n_lat][n_edge[n_lat]] = hub75_b1;
               end
               n_edge[n_lat]++;
            end
         end
         if (hub75_lat) begin
            if (!hub75_oe) n_overlap++;
            if (!busy) n_busy_bad++;
            if (n_lat < BP) lat_addr[n_lat] = hub75_addr;
            n_lat++;
         end
         if (hub75_addr !== prev_addr && !hub75_lat) n_addr_bad++;
         if (!hub75_oe) begin
            run_len++;
         end else if (run_len > 0) begin
            if (n_runs < 8) runs[n_runs] = run_len;
            n_runs++;
            run_len = 0;
         end
         prev_clk  = hub75_clk;
         prev_addr = hub75_addr;
         if (hub75_ready) break;
      end
      cycles = n;
   endtask

   task automatic check_pair(input string tag, input cols_t c, input logic [AW-1:0] addr,
                             input int cycles);
      string cn [3];
      cn[0] = "r"; cn[1] = "g"; cn[2] = "b";
      check_eq({tag, ".cycles"}, 64'(cycles), 64'(PAIR_CYC));
      check_eq({tag, ".n_lat"}, 64'(n_lat), 64'(BP));
      check_eq({tag, ".n_runs"}, 64'(n_runs), 64'(BP));
      check_eq({tag, ".lat_oe_overlap"}, 64'(n_overlap), 64'(0));
      check_eq({tag, ".addr_outside_lat"}, 64'(n_addr_bad), 64'(0));
      check_eq({tag, ".busy_at_lat"}, 64'(n_busy_bad), 64'(0));
      check_eq({tag, ".oe_low_at_clk"}, 64'(n_oe_clk), 64'(0));
      for (int p = 0; p < BP; p++) begin
         check_eq($sformatf("%s.p%0d.edges", tag, p), 64'(n_edge[p]), 64'(NR));
         check_eq($sformatf("%s.p%0d.addr", tag, p), 64'(lat_addr[p]), 64'(addr));
         check_eq($sformatf("%s.p%0d.oe_run", tag, p), 64'(runs[p]), 64'(BT << p));
         for (int h = 0; h < 2; h++)
            for (int k = 0; k < 3; k++)
               check_eq($sformatf("%s.p%0d.%s%0d", tag, p, cn[k], h),
                        64'(rec[h][k][p]), 64'(exp_bits(c, h, k, p)));
      end
   endtask

   initial begin
      cols_t c_a, c_b, c_c, c_d;
      int    cyc, n, idle_bad, nl;

      rst_in     = 1'b1;
      data_valid = 1'b0;
      columns    = '0;
      col_num1   = '0;
      repeat (3) step();
      check_eq("rst.ready", 64'(hub75_ready), 64'(0));
      check_eq("rst.addr", 64'(hub75_addr), 64'(0));
      check_eq("rst.rgb", 64'({hub75_r0, hub75_g0, hub75_b0, hub75_r1, hub75_g1, hub75_b1}), 64'(0));
      check_eq("rst.ctl", 64'({hub75_clk, hub75_lat, hub75_oe, busy}), 64'(4'b0010));

      // First cycle after release carries the single ready pulse.
      rst_in = 1'b0;
      step();
      check_eq("rel.ready", 64'(hub75_ready), 64'(1));
      check_eq("rel.ctl", 64'({hub75_clk, hub75_lat, hub75_oe, busy, hub75_addr}),
               64'({4'b0010, 5'd0}));
      step();
      check_eq("rel.ready_once", 64'(hub75_ready), 64'(0));
      check_eq("rel.busy_wait", 64'(busy), 64'(0));

      // All-ones pixels, strobe two cycles after ready.
      c_a = pat_const(9'h1FF, 9'h1FF);
      columns = c_a; col_num1 = 5'd5; data_valid = 1'b1;
      step();
      data_valid = 1'b0;
      run_pair(-10, c_a, '0, cyc);
      check_pair("ones", c_a, 5'd5, cyc);

      // Per-colour plane selection, top scan address.
      c_b = pat_const(9'b100_010_001, 9'h000);
      columns = c_b; col_num1 = AW'(SR - 1); data_valid = 1'b1;
      step();
      data_valid = 1'b0;
      run_pair(-10, c_b, '0, cyc);
      check_pair("planes", c_b, AW'(SR - 1), cyc);
      check_eq("planes.b0_p0", 64'(rec[0][2][0]), {64{1'b1}});
      check_eq("planes.r0_p2", 64'(rec[0][0][2]), {64{1'b1}});

      // Lost handshake: ready repeats after the timeout with idle outputs.
      idle_bad = 0;
      for (n = 1; n <= 3000; n++) begin
         step();
         if (hub75_ready) break;
         if (hub75_clk || hub75_lat || !hub75_oe || busy) idle_bad++;
      end
      check_eq("tmo.period", 64'(n), 64'(RT + 1));
      check_eq("tmo.idle", 64'(idle_bad), 64'(0));

      // Pixel order, with a stray strobe during SHIFT that must be ignored.
      c_c = pat_idx();
      columns = c_c; col_num1 = 5'd9; data_valid = 1'b1;
      step();
      data_valid = 1'b0;
      run_pair(10, c_a, 5'd3, cyc);
      check_pair("stray", c_c, 5'd9, cyc);

      // Reset during plane-1 display.
      c_d = pat_const(9'h1FF, 9'h000);
      columns = c_d; col_num1 = 5'd7; data_valid = 1'b1;
      step();
      data_valid = 1'b0;
      nl = 0;
      for (n = 0; n < 2000 && nl < 2; n++) begin
         step();
         if (hub75_lat) nl++;
      end
      check_eq("mid.reach_lat2", 64'(nl), 64'(2));
      repeat (3) step();
      check_eq("mid.in_display", 64'({hub75_oe, hub75_addr}), 64'({1'b0, 5'd7}));
      rst_in = 1'b1;
      step();
      check_eq("mid.rst_ctl", 64'({hub75_ready, hub75_clk, hub75_lat, hub75_oe, busy}),
               64'(5'b00010));
      check_eq("mid.rst_addr", 64'(hub75_addr), 64'(0));
      rst_in = 1'b0;
      step();
      check_eq("mid.req_ready", 64'({hub75_ready, hub75_oe, hub75_lat}), 64'(3'b110));
      step();
      check_eq("mid.req_once", 64'({hub75_ready, busy}), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
